regs_file: RTL
==============

REGS_FILE -- requirements
Module: regs_file

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port wb_op_c_i  input  32  write-back data from wb stage.
REQ-004 SHALL have port wb_reg_waddr_i  input  5  write-back destination register.
REQ-005 SHALL have port wb_reg_we_i  input  1  write-back enable.
REQ-006 SHALL have port id_reg1_raddr_i  input  5  read port 1 address.
REQ-007 SHALL have port id_reg2_raddr_i  input  5  read port 2 address.
REQ-008 SHALL have port regs_reg1_rdata_o  output  32  read port 1 data.
REQ-009 SHALL have port regs_reg2_rdata_o  output  32  read port 2 data.
REQ-010 SHALL have port id_issue_we_i  input  1  instruction issued that will write a register.
REQ-011 SHALL have port id_issue_waddr_i  input  5  destination of the issued instruction.
REQ-012 SHALL have port scb_clr_i  input  1  synchronous clear of all pending-write flags (pipeline flush).
REQ-013 SHALL have port regs_reg1_busy_o  output  1  read port 1 register has a pending write.
REQ-014 SHALL have port regs_reg2_busy_o  output  1  read port 2 register has a pending write.

Function
REQ-015 SHALL hold 31 writable 32-bit registers x1..x31; x0 SHALL read 32'h0 always and ignore writes.
REQ-016 SHALL write wb_op_c_i into x[wb_reg_waddr_i] on the rising edge when wb_reg_we_i=1 and waddr!=0.
REQ-017 SHALL drive both read ports combinationally (zero-cycle latency) from the addressed register.
REQ-018 SHALL keep one busy bit per register x1..x31; busy for x0 SHALL always be 0.
REQ-019 SHALL set busy[id_issue_waddr_i] on the edge when id_issue_we_i=1 and addr!=0.
REQ-020 SHALL clear busy[wb_reg_waddr_i] on the edge when wb_reg_we_i=1 and addr!=0.
REQ-021 Set and clear of the same address in one cycle: set SHALL win (busy=1 after edge).
REQ-022 scb_clr_i=1: all busy bits SHALL clear on the edge, then any same-cycle issue set SHALL apply (issue wins over flush).
REQ-023 scb_clr_i SHALL NOT affect register contents; wb writes in the same cycle SHALL still complete.
REQ-024 Both read ports addressing the same register SHALL return identical data and busy.
REQ-025 busy outputs SHALL be combinational from the busy bits per REQ-018..REQ-022 and REQ-028.

Reset
REQ-026 On rst_n=0, asynchronously: all registers SHALL be 32'h0, all busy bits 0; hence rdata outputs 32'h0 and busy outputs 0 while reset asserted.
REQ-027 Reset asserted mid-operation SHALL discard any write/issue of that cycle; first write accepted on first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro REGS_BYPASS_EN defined: when wb_reg_we_i=1, waddr!=0 and waddr equals a read address, that port SHALL return wb_op_c_i and its busy output SHALL be 0 unless the same address is also being issued in that cycle (then 1); undefined: that port SHALL return the stored (old) value and the stored busy bit.

Verification
REQ-029 Reset, then write x5=32'hDEADBEEF, read port1 addr 5 next cycle -> 32'hDEADBEEF; port2 addr 0 -> 32'h0.
REQ-030 Write x0=32'hFFFFFFFF, read addr 0 -> 32'h0; issue x0 -> busy stays 0.
REQ-031 Same cycle write x7=32'h12345678 and read addr 7 (x7 previously 32'h0) -> bypass build 32'h12345678, busy 0; non-bypass build 32'h0, busy as stored; both builds 32'h12345678 next cycle.
REQ-032 Issue x3 -> busy1=1 at addr 3 next cycle; wb write x3 -> busy 0 after edge; issue and wb x3 same cycle -> busy 1.
REQ-033 Issue x1, x2, x9 over 3 cycles, then scb_clr_i=1 with issue x4 -> after edge only x4 busy; register contents unchanged.
REQ-034 Assert rst_n=0 asynchronously between edges after loading x10=32'hA5A5A5A5 -> rdata for addr 10 goes 32'h0 without a clock edge.

Source files
------------

// File: rtl/regs_file_if.sv
// -----------------------------------------------------------------------------
// regs_file_if
//
// Groups the integer register file's pipeline-facing signals: the write-back
// port, the two read ports and the issue/scoreboard controls.
//
// Signals (same names as the register file's pipeline ports):
//   wb_op_c_i         [31:0] write-back data from the wb stage
//   wb_reg_waddr_i    [4:0]  write-back destination register
//   wb_reg_we_i              write-back enable
//   id_reg1_raddr_i   [4:0]  read port 1 address
//   id_reg2_raddr_i   [4:0]  read port 2 address
//   regs_reg1_rdata_o [31:0] read port 1 data
//   regs_reg2_rdata_o [31:0] read port 2 data
//   id_issue_we_i            issued instruction will write a register
//   id_issue_waddr_i  [4:0]  destination of the issued instruction
//   scb_clr_i                clear all pending-write flags (pipeline flush)
//   regs_reg1_busy_o         read port 1 register has a pending write
//   regs_reg2_busy_o         read port 2 register has a pending write
//
// Modports:
//   master : pipeline side (drives addresses, write-back and issue controls)
//   slave  : register file side (drives read data and busy flags)
//
// Handshake: there is no valid/ready pairing on this interface. Write-back and
// issue are single-cycle strobes qualified by their *_we_i bits and sampled on
// the rising clock edge; reads are combinational and always valid.
// -----------------------------------------------------------------------------
interface regs_file_if;
  logic [31:0] wb_op_c_i;
  logic [4:0]  wb_reg_waddr_i;
  logic        wb_reg_we_i;
  logic [4:0]  id_reg1_raddr_i;
  logic [4:0]  id_reg2_raddr_i;
  logic [31:0] regs_reg1_rdata_o;
  logic [31:0] regs_reg2_rdata_o;
  logic        id_issue_we_i;
  logic [4:0]  id_issue_waddr_i;
  logic        scb_clr_i;
  logic        regs_reg1_busy_o;
  logic        regs_reg2_busy_o;

  modport master (
    output wb_op_c_i,
    output wb_reg_waddr_i,
    output wb_reg_we_i,
    output id_reg1_raddr_i,
    output id_reg2_raddr_i,
    input  regs_reg1_rdata_o,
    input  regs_reg2_rdata_o,
    output id_issue_we_i,
    output id_issue_waddr_i,
    output scb_clr_i,
    input  regs_reg1_busy_o,
    input  regs_reg2_busy_o
  );

  modport slave (
    input  wb_op_c_i,
    input  wb_reg_waddr_i,
    input  wb_reg_we_i,
    input  id_reg1_raddr_i,
    input  id_reg2_raddr_i,
    output regs_reg1_rdata_o,
    output regs_reg2_rdata_o,
    input  id_issue_we_i,
    input  id_issue_waddr_i,
    input  scb_clr_i,
    output regs_reg1_busy_o,
    output regs_reg2_busy_o
  );
endinterface

// File: rtl/regs_file.sv
// -----------------------------------------------------------------------------
// regs_file
//
// 32 x 32-bit integer register file (x0 hard-wired to zero) with two
// combinational read ports, one write-back port and a per-register
// pending-write scoreboard (busy bits).
//
// Ports:
//   clk     : clock, all state updates on the rising edge
//   rst_n   : asynchronous active-low reset; clears registers and busy bits
//   bus     : regs_file_if.slave (write-back, read ports, issue, flush)
//
// Optional feature (compile-time macro REGS_BYPASS_EN):
//   defined   : a read port whose address matches a same-cycle write-back
//               returns the write-back data, and its busy flag reports only a
//               same-cycle issue to that register.
//   undefined : read ports always return the stored value and stored busy bit.
//
// Scoreboard update order within one edge:
//   1. flush (scb_clr_i) clears every busy bit
//   2. write-back clears the written register's bit
//   3. issue sets the issued register's bit
// Later steps override earlier ones, so issue beats both write-back and flush.
// -----------------------------------------------------------------------------
module regs_file (
  input  logic         clk,
  input  logic         rst_n,
  regs_file_if.slave   bus
);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // Entry 0 is reset to zero and never written; reads of address 0 are also
  // forced to zero at the port, so x0 cannot change regardless of stimulus.
  logic [31:0] regs_q [32];
  logic [31:0] busy_q;
  logic [31:0] busy_d;

  logic        wb_hit;     // qualified write-back to a real register
  logic        issue_hit;  // qualified issue to a real register

  assign wb_hit    = bus.wb_reg_we_i   && (bus.wb_reg_waddr_i   != 5'd0);
  assign issue_hit = bus.id_issue_we_i && (bus.id_issue_waddr_i != 5'd0);

  // ---------------------------------------------------------------------------
  // Register array write
  // ---------------------------------------------------------------------------
  // Flush does not gate this path: a write-back retiring in the flush cycle
  // belongs to an older, committed instruction and must land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'h0;
      end
    end else if (wb_hit) begin
      regs_q[bus.wb_reg_waddr_i] <= bus.wb_op_c_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard next state
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    if (bus.scb_clr_i) begin
      busy_d = 32'h0;
    end
    if (wb_hit) begin
      busy_d[bus.wb_reg_waddr_i] = 1'b0;
    end
    if (issue_hit) begin
      busy_d[bus.id_issue_waddr_i] = 1'b1;
    end
    // x0 never has a pending write.
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 32'h0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  logic [31:0] rd1_stored;
  logic [31:0] rd2_stored;
  logic        bz1_stored;
  logic        bz2_stored;

  always_comb begin
    rd1_stored = 32'h0;
    rd2_stored = 32'h0;
    bz1_stored = 1'b0;
    bz2_stored = 1'b0;
    if (bus.id_reg1_raddr_i != 5'd0) begin
      rd1_stored = regs_q[bus.id_reg1_raddr_i];
      bz1_stored = busy_q[bus.id_reg1_raddr_i];
    end
    if (bus.id_reg2_raddr_i != 5'd0) begin
      rd2_stored = regs_q[bus.id_reg2_raddr_i];
      bz2_stored = busy_q[bus.id_reg2_raddr_i];
    end
  end

`ifdef REGS_BYPASS_EN
  // Forward the write-back value to a reader of the same register. The busy
  // flag then reflects only what happens this cycle: the write-back retires
  // the pending write, unless a new producer is issued to the same register.
  logic byp1;
  logic byp2;
  logic iss1;
  logic iss2;

  assign byp1 = wb_hit && (bus.wb_reg_waddr_i == bus.id_reg1_raddr_i);
  assign byp2 = wb_hit && (bus.wb_reg_waddr_i == bus.id_reg2_raddr_i);
  assign iss1 = issue_hit && (bus.id_issue_waddr_i == bus.id_reg1_raddr_i);
  assign iss2 = issue_hit && (bus.id_issue_waddr_i == bus.id_reg2_raddr_i);

  always_comb begin
    bus.regs_reg1_rdata_o = byp1 ? bus.wb_op_c_i : rd1_stored;
    bus.regs_reg2_rdata_o = byp2 ? bus.wb_op_c_i : rd2_stored;
    bus.regs_reg1_busy_o  = byp1 ? iss1 : bz1_stored;
    bus.regs_reg2_busy_o  = byp2 ? iss2 : bz2_stored;
  end
`else
  always_comb begin
    bus.regs_reg1_rdata_o = rd1_stored;
    bus.regs_reg2_rdata_o = rd2_stored;
    bus.regs_reg1_busy_o  = bz1_stored;
    bus.regs_reg2_busy_o  = bz2_stored;
  end
`endif

endmodule
